// File: rtl/pla_rule_decoder.sv
// Programmable bank decoder. Each bus cycle captures a decode key, matches it
// against a masked rule table and drives one registered active-low chip select.
// Also holds an emulated 6510 processor port (DDR/DATA) that feeds the key.
module pla_rule_decoder #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned PAGE_W     = 4,
    parameter int unsigned VA_W       = 3,
    parameter int unsigned PORT_W     = 3,
    parameter int unsigned EXT_W      = 2,
    parameter int unsigned NUM_RULES  = 16,
    parameter int unsigned NUM_CS     = 8,
    parameter int unsigned DEFAULT_CS = 0,
    parameter int unsigned RAM_CS     = 0,
    localparam int unsigned KEY_W     = PAGE_W + PORT_W + EXT_W + 2,
    localparam int unsigned IDX_W     = $clog2(NUM_RULES),
    localparam int unsigned CS_W      = $clog2(NUM_CS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [VA_W-1:0]   va,
    input  logic              vic,
    input  logic              rw,
    input  logic [EXT_W-1:0]  ext_cfg,
    input  logic              cyc_start,
    input  logic              cyc_end,
    input  logic              cas_n,
    input  logic              pp_we,
    input  logic              pp_sel,
    input  logic [PORT_W-1:0] pp_wdata,
    output logic [PORT_W-1:0] pp_rdata,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic              cfg_valid,
    input  logic [KEY_W-1:0]  cfg_match,
    input  logic [KEY_W-1:0]  cfg_care,
    input  logic [CS_W-1:0]   cfg_target,
    output logic              cfg_ready,
    output logic              cfg_err,
    output logic [NUM_CS-1:0] cs_n,
    output logic              hit_valid,
    output logic [IDX_W-1:0]  hit_idx
);

    typedef enum logic [1:0] {IDLE = 2'd0, DECODE = 2'd1, ACTIVE = 2'd2} state_t;

    state_t              state;
    logic [PORT_W-1:0]   pp_ddr;
    logic [PORT_W-1:0]   pp_data;
    logic [PORT_W-1:0]   port_eff;
    logic [PAGE_W-1:0]   page_c;
    logic [KEY_W-1:0]    key_c;
    logic [KEY_W-1:0]    key_q;
    logic [NUM_CS-1:0]   cs_reg_n;
    logic [NUM_CS-1:0]   cs_sel_n;
    logic                hit_c;
    logic [IDX_W-1:0]    hit_idx_c;
    logic [CS_W-1:0]     tgt_c;
    logic                unused_addr;

    logic                rule_valid  [NUM_RULES];
    logic [KEY_W-1:0]    rule_match  [NUM_RULES];
    logic [KEY_W-1:0]    rule_care   [NUM_RULES];
    logic [CS_W-1:0]     rule_target [NUM_RULES];

    // Low address bits never take part in decode.
    assign unused_addr = ^addr[ADDR_W-PAGE_W-1:0];

    // Undriven port pins read high through the pull-ups.
    assign port_eff = (pp_ddr & pp_data) | ~pp_ddr;
    assign pp_rdata = port_eff;

    // VIC cycles decode on the VIC bank bits, CPU cycles on the top address bits.
    assign page_c = vic ? {va, {(PAGE_W-VA_W){1'b0}}} : addr[ADDR_W-1 -: PAGE_W];
    assign key_c  = {vic, rw, ext_cfg, port_eff, page_c};

    // Priority match: scanning high to low leaves the lowest hitting index.
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        for (int r = NUM_RULES - 1; r >= 0; r--) begin
            if (rule_valid[r] && (((key_q ^ rule_match[r]) & rule_care[r]) == '0)) begin
                hit_c     = 1'b1;
                hit_idx_c = IDX_W'(r);
            end
        end
    end

    assign tgt_c    = hit_c ? rule_target[hit_idx_c] : CS_W'(DEFAULT_CS);
    assign cs_sel_n = ~(NUM_CS'(1) << tgt_c);

    // RAM select is additionally qualified by the column strobe after the register.
    always_comb begin
        cs_n         = cs_reg_n;
        cs_n[RAM_CS] = cs_reg_n[RAM_CS] | cas_n;
    end

    // Processor port registers, writable in any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pp_ddr  <= '0;
            pp_data <= '0;
        end else if (pp_we) begin
            if (pp_sel) pp_data <= pp_wdata;
            else        pp_ddr  <= pp_wdata;
        end
    end

    // Rule table writes land only while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_RULES; r++) begin
                rule_valid[r]  <= 1'b0;
                rule_match[r]  <= '0;
                rule_care[r]   <= '0;
                rule_target[r] <= '0;
            end
        end else if (cfg_we && (state == IDLE)) begin
            rule_valid[cfg_idx]  <= cfg_valid;
            rule_match[cfg_idx]  <= cfg_match;
            rule_care[cfg_idx]   <= cfg_care;
            rule_target[cfg_idx] <= cfg_target;
        end
    end

    // Sticky flag for rule writes dropped outside idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            cfg_err <= 1'b0;
        else if (cfg_we && (state != IDLE)) cfg_err <= 1'b1;
    end

    // Bus-cycle FSM: capture key, decode, hold select until cycle end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            key_q     <= '0;
            cs_reg_n  <= '1;
            hit_valid <= 1'b0;
            hit_idx   <= '0;
            cfg_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (cyc_start) begin
                        key_q     <= key_c;
                        state     <= DECODE;
                        cfg_ready <= 1'b0;
                    end
                end
                DECODE: begin
                    if (cyc_end) begin
                        state     <= IDLE;
                        cfg_ready <= 1'b1;
                    end else begin
                        cs_reg_n  <= cs_sel_n;
                        hit_valid <= hit_c;
                        hit_idx   <= hit_idx_c;
                        state     <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (cyc_start) begin
                        cs_reg_n  <= '1;
                        hit_valid <= 1'b0;
                        key_q     <= key_c;
                        state     <= DECODE;
                    end else if (cyc_end) begin
                        cs_reg_n  <= '1;
                        hit_valid <= 1'b0;
                        state     <= IDLE;
                        cfg_ready <= 1'b1;
                    end
                end
                default: begin
                    cs_reg_n  <= '1;
                    hit_valid <= 1'b0;
                    state     <= IDLE;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pla_rule_decoder.sv
// Self-checking bench for pla_rule_decoder: directed scenarios plus randomized
// rule tables and accesses checked against a rule-table reference model.
module tb_pla_rule_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [2:0]  va;
    logic        vic, rw;
    logic [1:0]  ext_cfg;
    logic        cyc_start, cyc_end, cas_n;
    logic        pp_we, pp_sel;
    logic [2:0]  pp_wdata, pp_rdata;
    logic        cfg_we;
    logic [3:0]  cfg_idx;
    logic        cfg_valid;
    logic [10:0] cfg_match, cfg_care;
    logic [2:0]  cfg_target;
    logic        cfg_ready, cfg_err;
    logic [7:0]  cs_n;
    logic        hit_valid;
    logic [3:0]  hit_idx;

    int errors = 0;
    int checks = 0;

    // Reference state
    bit m_valid  [16];
    int m_match  [16];
    int m_care   [16];
    int m_target [16];
    int m_ddr, m_data;
    int exp_key;

    pla_rule_decoder dut (
        .clk(clk), .rst(rst), .addr(addr), .va(va), .vic(vic), .rw(rw),
        .ext_cfg(ext_cfg), .cyc_start(cyc_start), .cyc_end(cyc_end), .cas_n(cas_n),
        .pp_we(pp_we), .pp_sel(pp_sel), .pp_wdata(pp_wdata), .pp_rdata(pp_rdata),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid), .cfg_match(cfg_match),
        .cfg_care(cfg_care), .cfg_target(cfg_target), .cfg_ready(cfg_ready),
        .cfg_err(cfg_err), .cs_n(cs_n), .hit_valid(hit_valid), .hit_idx(hit_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int r = 0; r < 16; r++) begin
            m_valid[r] = 1'b0; m_match[r] = 0; m_care[r] = 0; m_target[r] = 0;
        end
        m_ddr = 0; m_data = 0;
    endfunction

    function automatic int model_port();
        int pe = 0;
        for (int i = 0; i < 3; i++) begin
            if (((m_ddr >> i) & 1) == 0) pe += (1 << i);
            else if (((m_data >> i) & 1) == 1) pe += (1 << i);
        end
        return pe;
    endfunction

    function automatic int make_key(int a, int v, int vc, int r, int e);
        int page = (vc != 0) ? v * 2 : (a >> 12) & 15;
        return page + model_port() * 16 + e * 128 + r * 512 + vc * 1024;
    endfunction

    // First valid rule whose cared bits equal the key wins; else RAM channel 0.
    function automatic void model_decode(input int key, output bit hit, output int idx, output int tgt);
        hit = 1'b0; idx = 0; tgt = 0;
        for (int r = 0; r < 16; r++) begin
            if (m_valid[r] && (((key ^ m_match[r]) & m_care[r]) == 0)) begin
                hit = 1'b1; idx = r; tgt = m_target[r];
                break;
            end
        end
    endfunction

    function automatic logic [7:0] cs_for(int tgt);
        logic [7:0] v = 8'hFF;
        v[tgt] = 1'b0;
        return v;
    endfunction

    task automatic cfg_write(input int idx, input bit valid, input int match, input int care,
                             input int tgt, input bit accepted);
        cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_valid = valid;
        cfg_match = 11'(match); cfg_care = 11'(care); cfg_target = 3'(tgt);
        tick();
        cfg_we = 1'b0;
        if (accepted) begin
            m_valid[idx] = valid; m_match[idx] = match; m_care[idx] = care; m_target[idx] = tgt;
        end
    endtask

    task automatic pp_write(input bit sel, input int val);
        pp_we = 1'b1; pp_sel = sel; pp_wdata = 3'(val);
        tick();
        pp_we = 1'b0;
        if (sel) m_data = val; else m_ddr = val;
    endtask

    // Drive a cycle start through edge N; the key model uses the port as of that edge.
    task automatic start_access(input int a, input int v, input int vc, input int r, input int e);
        addr = 16'(a); va = 3'(v); vic = vc[0]; rw = r[0]; ext_cfg = 2'(e);
        exp_key = make_key(a, v, vc, r, e);
        cyc_start = 1'b1;
        tick();
        cyc_start = 1'b0;
    endtask

    task automatic end_cycle();
        cyc_end = 1'b1;
        tick();
        cyc_end = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        model_reset();
        checks++; if (cs_n !== 8'hFF) begin errors++; $display("FAIL reset_cs_n got=%h exp=ff", cs_n); end
        checks++; if (hit_valid !== 1'b0 || hit_idx !== 4'd0) begin errors++; $display("FAIL reset_hit got=%b/%0d exp=0/0", hit_valid, hit_idx); end
        checks++; if (cfg_err !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg got err=%b rdy=%b exp 0/1", cfg_err, cfg_ready); end
        checks++; if (pp_rdata !== 3'b111) begin errors++; $display("FAIL reset_pp got=%b exp=111", pp_rdata); end
    endtask

    task automatic test_default();
        start_access(16'hA000, 0, 0, 1, 0);
        checks++; if (cs_n !== 8'hFF) begin errors++; $display("FAIL default_latency got=%h exp=ff", cs_n); end
        tick();
        checks++; if (cs_n !== 8'hFE || hit_valid !== 1'b0) begin errors++; $display("FAIL default_cs got=%h/%b exp=fe/0", cs_n, hit_valid); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL active_ready got=%b exp=0", cfg_ready); end
        end_cycle();
        checks++; if (cs_n !== 8'hFF || cfg_ready !== 1'b1) begin errors++; $display("FAIL end_cycle got=%h/%b exp=ff/1", cs_n, cfg_ready); end
    endtask

    task automatic test_priority();
        cfg_write(0, 1, 'hA + ('b011 << 4), 'hF + ('b011 << 4), 1, 1);
        cfg_write(1, 1, 'hA, 'hF, 2, 1);
        start_access(16'hA000, 0, 0, 1, 0);
        tick();
        checks++; if (cs_n !== 8'hFD || hit_valid !== 1'b1 || hit_idx !== 4'd0) begin errors++; $display("FAIL prio_rule0 got=%h/%b/%0d exp=fd/1/0", cs_n, hit_valid, hit_idx); end
        end_cycle();
        pp_write(0, 3'b111);
        pp_write(1, 3'b000);
        checks++; if (pp_rdata !== 3'b000) begin errors++; $display("FAIL pp_rdata got=%b exp=000", pp_rdata); end
        start_access(16'hA123, 0, 0, 1, 0);
        tick();
        checks++; if (cs_n !== 8'hFB || hit_idx !== 4'd1) begin errors++; $display("FAIL prio_rule1 got=%h/%0d exp=fb/1", cs_n, hit_idx); end
        end_cycle();
    endtask

    task automatic test_catchall();
        cfg_write(3, 1, 0, 0, 4, 1);
        cfg_write(5, 1, 'h7FF, 0, 5, 1);
        start_access(16'h1000, 0, 0, 0, 2);
        tick();
        checks++; if (cs_n !== 8'hEF || hit_idx !== 4'd3 || hit_valid !== 1'b1) begin errors++; $display("FAIL catchall got=%h/%0d/%b exp=ef/3/1", cs_n, hit_idx, hit_valid); end
        end_cycle();
        // VIC page {va,0}: va=5 -> page A, rule1 still wins over the catch-all
        start_access(16'h0000, 5, 1, 1, 0);
        tick();
        checks++; if (cs_n !== 8'hFB || hit_idx !== 4'd1) begin errors++; $display("FAIL vic_page got=%h/%0d exp=fb/1", cs_n, hit_idx); end
        end_cycle();
    endtask

    task automatic test_abort();
        start_access(16'h1000, 0, 0, 1, 0);
        end_cycle();
        checks++; if (cs_n !== 8'hFF || cfg_ready !== 1'b1 || hit_valid !== 1'b0) begin errors++; $display("FAIL abort got=%h/%b/%b exp=ff/1/0", cs_n, cfg_ready, hit_valid); end
        tick();
        checks++; if (cs_n !== 8'hFF) begin errors++; $display("FAIL abort_hold got=%h exp=ff", cs_n); end
    endtask

    task automatic test_back_to_back();
        start_access(16'hA000, 0, 0, 1, 0);
        tick();
        start_access(16'h2000, 0, 0, 1, 0);
        checks++; if (cs_n !== 8'hFF) begin errors++; $display("FAIL b2b_gap got=%h exp=ff", cs_n); end
        tick();
        checks++; if (cs_n !== 8'hEF || hit_idx !== 4'd3) begin errors++; $display("FAIL b2b_new got=%h/%0d exp=ef/3", cs_n, hit_idx); end
        cyc_end = 1'b1;
        start_access(16'hA000, 0, 0, 1, 0);
        cyc_end = 1'b0;
        checks++; if (cs_n !== 8'hFF) begin errors++; $display("FAIL b2b_both_gap got=%h exp=ff", cs_n); end
        tick();
        checks++; if (cs_n !== 8'hFB || hit_idx !== 4'd1) begin errors++; $display("FAIL b2b_both_new got=%h/%0d exp=fb/1", cs_n, hit_idx); end
        end_cycle();
    endtask

    task automatic test_cfg_err();
        start_access(16'h3000, 0, 0, 1, 0);
        tick();
        cfg_write(3, 1, 0, 0, 6, 0);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_set got=%b exp=1", cfg_err); end
        end_cycle();
        start_access(16'h3000, 0, 0, 1, 0);
        tick();
        checks++; if (cs_n !== 8'hEF) begin errors++; $display("FAIL cfg_dropped got=%h exp=ef", cs_n); end
        end_cycle();
        cfg_write(3, 1, 0, 0, 6, 1);
        start_access(16'h3000, 0, 0, 1, 0);
        tick();
        checks++; if (cs_n !== 8'hBF || cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_idle_write got=%h/%b exp=bf/1", cs_n, cfg_err); end
        end_cycle();
    endtask

    task automatic test_cas();
        cfg_write(2, 1, 0, 'hF, 0, 1);
        start_access(16'h0400, 0, 0, 1, 0);
        tick();
        cas_n = 1'b1;
        #1;
        checks++; if (cs_n !== 8'hFF || hit_idx !== 4'd2) begin errors++; $display("FAIL cas_high got=%h/%0d exp=ff/2", cs_n, hit_idx); end
        cas_n = 1'b0;
        #1;
        checks++; if (cs_n !== 8'hFE) begin errors++; $display("FAIL cas_low got=%h exp=fe", cs_n); end
        end_cycle();
    endtask

    task automatic test_random();
        bit hit; int idx, tgt;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) == 0)
                cfg_write($urandom_range(0, 15), $urandom_range(0, 3) != 0, $urandom & 'h7FF,
                          $urandom & $urandom & 'h7FF, $urandom_range(0, 7), 1);
            if ($urandom_range(0, 3) == 0) pp_write($urandom_range(0, 1), $urandom_range(0, 7));
            start_access($urandom & 'hFFFF, $urandom_range(0, 7), $urandom_range(0, 1),
                         $urandom_range(0, 1), $urandom_range(0, 3));
            model_decode(exp_key, hit, idx, tgt);
            tick();
            checks++;
            if (cs_n !== cs_for(tgt) || hit_valid !== hit || (hit && hit_idx !== 4'(idx))) begin
                errors++;
                $display("FAIL random[%0d] key=%h got cs=%h v=%b i=%0d exp cs=%h v=%b i=%0d",
                         it, exp_key, cs_n, hit_valid, hit_idx, cs_for(tgt), hit, idx);
            end
            end_cycle();
        end
    endtask

    task automatic test_reset_mid();
        cfg_write(0, 1, 0, 0, 7, 1);
        start_access(16'h5000, 0, 0, 1, 0);
        tick();
        checks++; if (cs_n !== 8'h7F) begin errors++; $display("FAIL pre_reset got=%h exp=7f", cs_n); end
        rst = 1'b1;
        #1;
        checks++; if (cs_n !== 8'hFF || hit_valid !== 1'b0 || pp_rdata !== 3'b111) begin errors++; $display("FAIL async_reset got=%h/%b/%b exp=ff/0/111", cs_n, hit_valid, pp_rdata); end
        tick();
        rst = 1'b0;
        model_reset();
        start_access(16'h5000, 0, 0, 1, 0);
        tick();
        checks++; if (cs_n !== 8'hFE || hit_valid !== 1'b0) begin errors++; $display("FAIL rules_cleared got=%h/%b exp=fe/0", cs_n, hit_valid); end
        end_cycle();
    endtask

    initial begin
        rst = 1'b1; addr = '0; va = '0; vic = 1'b0; rw = 1'b1; ext_cfg = '0;
        cyc_start = 1'b0; cyc_end = 1'b0; cas_n = 1'b0;
        pp_we = 1'b0; pp_sel = 1'b0; pp_wdata = '0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_valid = 1'b0; cfg_match = '0; cfg_care = '0; cfg_target = '0;
        test_reset();
        test_default();
        test_priority();
        test_catchall();
        test_abort();
        test_back_to_back();
        test_cfg_err();
        test_cas();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
